// File: rtl/integration_pkg.sv
// Shared AHB-Lite arbitration types, transfer/burst encodings and burst length helper.
// Pure declarations: no latency, no backpressure.
package integration_pkg;

    localparam int master_number = 4;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        BURST  = 2'd1,
        LOCKED = 2'd2
    } ahb_arb_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    // Undefined-length bursts (SINGLE/INCR) report 0 so they never lock the grant.
    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  return 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  return 5'd8;
            HBURST_WRAP16, HBURST_INCR16: return 5'd16;
            default:                      return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_arbiter_prio_enc.sv
// Fixed-priority request encoder: lowest requesting index wins, else the top (default) master.
// Combinational, zero latency, no backpressure.
module ahb_arb_prio_enc #(
    parameter int NUM_MASTERS = 4
) (
    input  logic [NUM_MASTERS-1:0] req,
    output logic [3:0]             win_idx,
    output logic                   win_dflt
);

    always_comb begin
        win_idx  = 4'(NUM_MASTERS - 1);
        win_dflt = 1'b1;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_idx  = 4'(i);
                win_dflt = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB-Lite fixed-priority arbiter keeping fixed bursts and locked sequences intact.
// Grant registers one hready edge after a request; hready=0 stalls every register.
module ahb_arbiter
    import integration_pkg::*;
#(
    parameter int NUM_MASTERS = integration_pkg::master_number
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic                   hready,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [3:0]             hmaster,
    output logic                   hmastlock
);

    ahb_arb_state_e         state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [3:0]             hmaster_q, hmaster_d;
    logic                   hmastlock_q, hmastlock_d;

    logic [3:0]             win_idx;
    logic                   win_dflt;
    logic [NUM_MASTERS-1:0] win_oh;
    logic [NUM_MASTERS-1:0] lock_req;
    logic [3:0]             owner_idx;
    logic                   owner_lock;
    logic                   win_lock;
    logic [4:0]             beats;
    logic                   burst_start;

    ahb_arb_prio_enc #(.NUM_MASTERS(NUM_MASTERS)) u_prio_enc (
        .req      (hbusreq),
        .win_idx  (win_idx),
        .win_dflt (win_dflt)
    );

    assign lock_req    = hbusreq & hlock;
    assign owner_lock  = |(lock_req & grant_q);
    assign win_lock    = !win_dflt && |(lock_req & win_oh);
    assign beats       = burst_beats(hburst);
    assign burst_start = (state_q != BURST) && (htrans == HTRANS_NONSEQ) && (beats != 5'd0);

    always_comb begin
        win_oh    = '0;
        owner_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            win_oh[i] = (win_idx == 4'(i));
            if (grant_q[i]) begin
                owner_idx = owner_idx | 4'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        if (hready) begin
            hmaster_d   = owner_idx;
            hmastlock_d = owner_lock;

            if (burst_start) begin
                cnt_d = 4'(beats - 5'd1);
            end else if (htrans == HTRANS_IDLE) begin
                cnt_d = '0;
            end else if (htrans == HTRANS_SEQ && cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end

            case (state_q)
                ARB: begin
                    // A burst starting now belongs to the current owner, so the grant stays put.
                    if (burst_start) begin
                        state_d = owner_lock ? LOCKED : BURST;
                    end else begin
                        grant_d = win_oh;
                        state_d = win_lock ? LOCKED : ARB;
                    end
                end
                BURST: begin
                    if (cnt_d == 4'd0) begin
                        state_d = ARB;
                    end
                end
                LOCKED: begin
                    if (!owner_lock) begin
                        state_d = (cnt_d != 4'd0) ? BURST : ARB;
                    end
                end
                default: state_d = ARB;
            endcase
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q     <= ARB;
            cnt_q       <= '0;
            grant_q     <= {1'b1, {(NUM_MASTERS-1){1'b0}}};
            hmaster_q   <= 4'(NUM_MASTERS - 1);
            hmastlock_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            hmaster_q   <= hmaster_d;
            hmastlock_q <= hmastlock_d;
        end
    end

    assign hgrant    = grant_q;
    assign hmaster   = hmaster_q;
    assign hmastlock = hmastlock_q;

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Central AHB-Lite bus arbiter for the multi-master integration. It takes per-master `hbusreq`/`hlock` requests and produces the one-hot `hgrant`, the registered `hmaster` index and `hmastlock` that the request interface and its checkers observe. It uses fixed priority: master 0 is highest, and master `NUM_MASTERS-1` is both the lowest priority and the default master. Fixed-length bursts and locked sequences are never broken.

## Interface
- `NUM_MASTERS`, default `integration_pkg::master_number`: number of masters, legal range 2..16.
- `hclk` in 1: bus clock; all state changes on its rising edge.
- `hreset` in 1: asynchronous, active-high reset.
- `hbusreq` in NUM_MASTERS: per-master bus request.
- `hlock` in NUM_MASTERS: per-master lock request; only meaningful together with `hbusreq`.
- `hready` in 1: bus transfer-complete from the slave mux.
- `htrans` in 2: transfer type of the current owner; IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `hburst` in 3: burst type of the current owner; SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7.
- `hgrant` out NUM_MASTERS: one-hot registered grant.
- `hmaster` out 4: index of the address-phase owner; zero-extended.
- `hmastlock` out 1: the current owner's transfer is locked.

## Operation
- Reset values:
  - `hgrant` = 1<<(NUM_MASTERS-1).
  - `hmaster` = NUM_MASTERS-1.
  - `hmastlock` = 0.
  - state ARB, beat counter 0.
- Winner selection: the lowest index with `hbusreq` set. If no request is set, the winner is the default master NUM_MASTERS-1.
- State ARB, on an edge with `hready`=1:
  - `hgrant` is set to one-hot(winner).
  - If the granted master g has `hbusreq[g]` and `hlock[g]` both set, the next state is LOCKED.
- Burst start, evaluated in ARB or LOCKED on an edge with `hready`=1 and `htrans`=NONSEQ:
  - `hburst` gives the beat count: 4 for WRAP4/INCR4, 8 for WRAP8/INCR8, 16 for WRAP16/INCR16.
  - For those bursts the counter is loaded with beats-1 and the state moves to BURST.
  - SINGLE and INCR do not enter BURST; INCR may be re-arbitrated at any beat.
- State BURST: `hgrant` is frozen.
  - The counter decrements on each edge with `hready`=1 and `htrans`=SEQ.
  - BUSY holds the counter.
  - When the counter reaches 0, the state moves to ARB and re-arbitration happens on the next `hready` edge.
  - IDLE with `hready`=1 (early termination) moves immediately to ARB with counter 0.
- State LOCKED: `hgrant` is held on the owner g.
  - The state moves to ARB on the edge where `hlock[g]`=0 or `hbusreq[g]`=0.
  - If a fixed burst is still active at that edge, the state moves to BURST instead.
  - LOCKED takes precedence over BURST while the lock is held.
- `hmaster` and `hmastlock` update only on edges with `hready`=1:
  - `hmaster` <= index(`hgrant`).
  - `hmastlock` <= `hlock`[index(`hgrant`)] & `hbusreq`[index(`hgrant`)].
- `hready`=0: all state, the counter, `hgrant`, `hmaster` and `hmastlock` hold.
- Reset asserted mid-burst or mid-lock: all outputs return to their reset values asynchronously, and arbitration restarts in ARB.

## Timing
- Request to grant: a request sampled at edge n appears on `hgrant` after edge n, when in ARB with `hready`=1.
- Grant to ownership: `hmaster` follows `hgrant` one `hready` edge later.
- When all requests drop, the default master is granted after at most 2 edges with `hready` in ARB. This is inside the 3-cycle default-master check.
- `hgrant` is one-hot at every cycle, including reset, so `$onehot0` always holds.
- Simultaneous events:
  - Requests from higher masters during BURST/LOCKED are not serviced until the return to ARB.
  - If the lock drops on the same edge as the last burst beat, the next state is ARB.

## Structure
- Shared items in `integration_pkg`:
  - `ahb_arb_state_e` {ARB, BURST, LOCKED}.
  - `htrans`/`hburst` localparams.
  - The `burst_beats(hburst)` function, returning 0 for SINGLE/INCR.
- Sub-module `ahb_arb_prio_enc`: combinational fixed-priority encoder producing the winner index and a default flag. Everything else lives in `ahb_arbiter`.

## Test plan
- Release `hreset` with no requests, `hready`=1 -> `hgrant`=4'b1000 and `hmaster`=3 (NUM_MASTERS=4), `hmastlock`=0.
- Assert `hbusreq`=4'b0110 -> `hgrant`=4'b0010 one edge later, `hmaster`=1 one edge after that. Drop all requests -> `hgrant`=4'b1000 within 2 edges.
- Master 2 issues INCR4 (NONSEQ+3 SEQ), with master 0 requesting from beat 2 and one BUSY inserted -> `hgrant` stays 4'b0100 until the 3rd SEQ completes, then becomes 4'b0001.
- Master 1 holds `hlock`+`hbusreq` for 5 cycles while master 0 requests -> grant held and `hmastlock`=1. Drop `hlock` -> master 0 granted on the next `hready` edge.
- Hold `hready`=0 for 3 cycles during an arbitration change -> `hgrant`, `hmaster` and the counter are frozen.
- Assert `hreset` mid-INCR8 at beat 4 -> outputs return to their reset values immediately, and a new request is granted normally after release.
